// File: rtl/md5_hit_capture.sv
// Result capture behind the MD5 pipeline. It holds the 128-bit target digest and
// tags each digest with its guess ordinal by delaying guess_valid by the pipeline
// latency. It latches the first matching ordinal and a saturating match count,
// and it reports a clean miss once the generator is done and the pipeline is empty.
module md5_hit_capture #(
  parameter int unsigned PIPE_LATENCY = 65,
  parameter int unsigned IDX_W        = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             target_we,
  input  logic [1:0]       target_sel,
  input  logic [31:0]      target_data,
  input  logic             guess_valid,
  input  logic             gen_done,
  input  logic [31:0]      hashA,
  input  logic [31:0]      hashB,
  input  logic [31:0]      hashC,
  input  logic [31:0]      hashD,
  output logic             hit,
  output logic             miss,
  output logic             busy,
  output logic [IDX_W-1:0] hit_index,
  output logic [7:0]       hit_count
);

  typedef enum logic [1:0] {StIdle, StArmed, StHit, StMiss} state_e;

  state_e                  state_q, state_d;
  logic [127:0]            target_q;
  logic [PIPE_LATENCY-1:0] dly_q, dly_d;
  logic [IDX_W-1:0]        out_idx_q, out_idx_d;
  logic [IDX_W-1:0]        hit_index_d;
  logic [7:0]              hit_count_d;
  logic                    out_valid, match, drain, shift_in;

  // Compare the digest against the target and detect a fully drained pipeline.
  always_comb begin
    out_valid = dly_q[PIPE_LATENCY-1];
    match     = out_valid && ({hashA, hashB, hashC, hashD} == target_q);
    drain     = gen_done && !guess_valid && (dly_q == '0);
  end

  // Valid delay line: guesses are tracked only while a run is active (or on arm).
  always_comb begin
    shift_in = guess_valid && (arm || state_q == StArmed || state_q == StHit);
    if (arm) begin
      dly_d    = '0;
      dly_d[0] = guess_valid;
    end else begin
      dly_d = (dly_q << 1) | PIPE_LATENCY'(shift_in);
    end
  end

  // Next state, output ordinal counter and result registers.
  always_comb begin
    state_d     = state_q;
    out_idx_d   = out_valid ? out_idx_q + IDX_W'(1) : out_idx_q;
    hit_index_d = hit_index;
    hit_count_d = hit_count;
    if (arm) begin
      state_d     = StArmed;
      out_idx_d   = '0;
      hit_index_d = '0;
      hit_count_d = '0;
    end else begin
      unique case (state_q)
        StArmed: begin
          // A match wins over a coincident drain.
          if (match) begin
            hit_index_d = out_idx_q;
            hit_count_d = 8'd1;
            state_d     = StHit;
          end else if (drain) begin
            state_d = StMiss;
          end
        end
        StHit: begin
          if (match && hit_count != 8'hff) hit_count_d = hit_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      dly_q     <= '0;
      out_idx_q <= '0;
      hit_index <= '0;
      hit_count <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      out_idx_q <= out_idx_d;
      hit_index <= hit_index_d;
      hit_count <= hit_count_d;
      hit       <= (state_d == StHit);
      miss      <= (state_d == StMiss);
      busy      <= (state_d == StArmed);
    end
  end

  // Target words are frozen while a run is armed; arm does not clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= '0;
    end else if (target_we && state_q != StArmed) begin
      unique case (target_sel)
        2'd0: target_q[127:96] <= target_data;
        2'd1: target_q[95:64]  <= target_data;
        2'd2: target_q[63:32]  <= target_data;
        2'd3: target_q[31:0]   <= target_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_hit_capture.sv
// Self-checking bench for md5_hit_capture. The bench models the MD5 pipeline as a
// queue of scheduled digests. The expected first hit or miss (value and cycle) is
// pushed into a scoreboard that a monitor pops when hit or miss rises. After each
// run, the final result registers are compared with the run's match list.
module tb_md5_hit_capture;
  localparam int L  = 65;
  localparam int IW = 48;

  logic          clk = 1'b0;
  logic          reset, arm, target_we, guess_valid, gen_done;
  logic [1:0]    target_sel;
  logic [31:0]   target_data, hashA, hashB, hashC, hashD;
  logic          hit, miss, busy;
  logic [IW-1:0] hit_index;
  logic [7:0]    hit_count;

  md5_hit_capture #(.PIPE_LATENCY(L), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .target_we(target_we), .target_sel(target_sel),
    .target_data(target_data), .guess_valid(guess_valid), .gen_done(gen_done),
    .hashA(hashA), .hashB(hashB), .hashC(hashC), .hashD(hashD),
    .hit(hit), .miss(miss), .busy(busy), .hit_index(hit_index), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {int due; bit m;} pend_t;
  typedef struct {bit is_hit; int cyc; longint idx;} ev_t;

  pend_t        pend[$];
  ev_t          evq[$];
  bit           mflag[$];
  logic [127:0] model_tgt = '0;

  // Pipeline model: a digest appears L cycles after its guess.
  // Idle cycles often carry the target value to show that match needs a valid output.
  always @(negedge clk) begin
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    if (pend.size() > 0 && pend[0].due == cyc) begin
      d = pend[0].m ? model_tgt : (model_tgt ^ (128'd1 << $urandom_range(127, 0)));
      void'(pend.pop_front());
    end else if ($urandom_range(1, 0) == 1) begin
      d = model_tgt;
    end
    {hashA, hashB, hashC, hashD} = d;
  end

  // Monitor: when hit or miss rises, pop the expected event and compare it.
  logic ph = 1'b0;
  logic pm = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!reset && ((hit && !ph) || (miss && !pm))) begin
      if (evq.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_event: got hit=%0d miss=%0d, expected none (cycle %0d)",
                 hit, miss, cyc);
      end else begin
        e = evq.pop_front();
        check("event_is_hit", longint'(hit), longint'(e.is_hit));
        check("event_cycle", cyc, e.cyc);
        check("event_busy", longint'(busy), 0);
        if (e.is_hit) begin
          check("event_hit_index", longint'(hit_index), e.idx);
          check("event_hit_count", longint'(hit_count), 1);
          check("event_no_miss", longint'(miss), 0);
        end
      end
    end
    ph = hit;
    pm = miss;
  end

  task automatic write_target(input logic [127:0] t);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      target_we   = 1'b1;
      target_sel  = 2'(w);
      target_data = t[127-32*w -: 32];
    end
    @(negedge clk);
    target_we = 1'b0;
    model_tgt = t;
  endtask

  // One armed run over the guesses in mflag. This is the reference model: first
  // match index, match count, and event timing are derived from the plan.
  task automatic run(input bit done, input bit arm_first, input bit armed_wr);
    int n = mflag.size();
    int off[$];
    int first = -1;
    int cnt = 0;
    int j = 0;
    int c0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) off.push_back(arm_first ? 0 : int'($urandom_range(3, 1)));
      else off.push_back(off[i-1] + 1 + int'($urandom_range(2, 0)));
      if (mflag[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    @(negedge clk);
    c0 = cyc;
    if (first >= 0) evq.push_back('{1'b1, c0 + off[first] + L + 1, longint'(first)});
    else if (done) evq.push_back('{1'b0, c0 + off[n-1] + L + 2, 0});
    for (int k = 0; k <= off[n-1]; k++) begin
      arm = (k == 0);
      if (k == 0) gen_done = 1'b0;
      target_we   = armed_wr && (k == 2);
      target_sel  = 2'($urandom);
      target_data = $urandom;
      guess_valid = (j < n && off[j] == k);
      if (guess_valid) begin
        pend.push_back('{c0 + k + L, mflag[j]});
        if (done && j == n - 1) gen_done = 1'b1;
        j++;
      end
      @(negedge clk);
    end
    arm = 1'b0;
    guess_valid = 1'b0;
    target_we = 1'b0;
    repeat (L + 4) @(negedge clk);
    check("final_hit", longint'(hit), longint'(first >= 0));
    check("final_miss", longint'(miss), longint'(first < 0 && done));
    check("final_busy", longint'(busy), longint'(first < 0 && !done));
    check("final_hit_index", longint'(hit_index), (first >= 0) ? first : 0);
    check("final_hit_count", longint'(hit_count), (cnt > 255) ? 255 : cnt);
    mflag.delete();
  endtask

  task automatic reset_async();
    #2 reset = 1'b1;
    #1;
    check("async_hit", longint'(hit), 0);
    check("async_miss", longint'(miss), 0);
    check("async_busy", longint'(busy), 0);
    check("async_hit_index", longint'(hit_index), 0);
    check("async_hit_count", longint'(hit_count), 0);
    pend.delete();
    evq.delete();
    model_tgt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit done, ended_armed;
    int n;
    reset = 1'b1; arm = 1'b0; target_we = 1'b0; target_sel = '0; target_data = '0;
    guess_valid = 1'b0; gen_done = 1'b0;
    #1;
    check("reset_hit", longint'(hit), 0);
    check("reset_miss", longint'(miss), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_hit_index", longint'(hit_index), 0);
    check("reset_hit_count", longint'(hit_count), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // IDLE ignores guesses even though the digest equals the (zero) target.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      guess_valid = i[0];
    end
    @(negedge clk);
    guess_valid = 1'b0;
    repeat (2 * L) @(negedge clk);
    check("idle_hit_count", longint'(hit_count), 0);
    check("idle_hit", longint'(hit), 0);
    check("idle_miss", longint'(miss), 0);
    check("idle_busy", longint'(busy), 0);

    write_target(128'hdda9b9a6_72aff2e0_3c5e7d11_a1051895);
    for (int i = 0; i < 10; i++) mflag.push_back(i == 6);
    run(1'b1, 1'b0, 1'b0);

    // Three matches; the first guess coincides with arm.
    for (int i = 0; i < 12; i++) mflag.push_back(i == 2 || i == 5 || i == 9);
    run(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++) mflag.push_back(1'b1);
    run(1'b1, 1'b0, 1'b0);

    write_target({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 20; i++) mflag.push_back(1'b0);
    run(1'b1, 1'b0, 1'b0);

    // The last in-flight guess matches while the generator is done.
    for (int i = 0; i < 8; i++) mflag.push_back(i == 7);
    run(1'b1, 1'b0, 1'b0);

    // A target write while armed is ignored: old-target digests still hit.
    for (int i = 0; i < 10; i++) mflag.push_back(i == 4);
    run(1'b1, 1'b0, 1'b1);

    ended_armed = 1'b0;
    for (int r = 0; r < 6; r++) begin
      int first_m = -1;
      if (!ended_armed) write_target({$urandom, $urandom, $urandom, $urandom});
      n = $urandom_range(40, 3);
      for (int i = 0; i < n; i++) begin
        mflag.push_back($urandom_range(7, 0) == 0);
        if (mflag[i] && first_m < 0) first_m = i;
      end
      done = 1'(($urandom_range(1, 0)));
      ended_armed = (first_m < 0) && !done;
      run(done, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    // Asynchronous reset while in HIT.
    if (ended_armed) begin
      for (int i = 0; i < 5; i++) mflag.push_back(i == 1);
      run(1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    reset_async();

    // Asynchronous reset while armed with guesses in flight.
    write_target(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    @(negedge clk);
    arm = 1'b1;
    guess_valid = 1'b1;
    pend.push_back('{cyc + L, 1'b1});
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      arm = 1'b0;
      pend.push_back('{cyc + L, 1'b1});
    end
    @(negedge clk);
    guess_valid = 1'b0;
    check("armed_busy_before_reset", longint'(busy), 1);
    reset_async();

    // Re-arm after reset: the index restarts at 0.
    write_target(128'hfeed_face_cafe_beef_0bad_f00d_dead_c0de);
    for (int i = 0; i < 9; i++) mflag.push_back(i == 3 || i == 6);
    run(1'b1, 1'b1, 1'b0);

    check("scoreboard_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
